// File: rtl/sd_wrrarb_n_if.sv
// sd_wrrarb_n_if
// Bundles the request side, weight configuration and output side of the
// weighted round-robin arbiter so they travel as one port.
//   c_data     : all requester data, requester i at [i*width +: width]
//   c_srdy     : per-requester source-ready
//   c_drdy     : per-requester accept (at most one bit set)
//   cfg_wr     : weight write strobe
//   cfg_idx    : index of the weight to write
//   cfg_weight : weight value to write
//   p_data     : registered output data
//   p_grant    : one-hot source of p_data, zero when p_srdy is low
//   p_srdy     : registered output valid
//   p_drdy     : downstream accept
// The master modport is the side that drives requests/config and accepts
// output; the slave modport is the arbiter itself.
interface sd_wrrarb_n_if #(
   parameter int inputs    = 4,
   parameter int width     = 8,
   parameter int weight_sz = 3
);
   localparam int idxSz = $clog2(inputs);

   logic [inputs*width-1:0] c_data;
   logic [inputs-1:0]       c_srdy;
   logic [inputs-1:0]       c_drdy;
   logic                    cfg_wr;
   logic [idxSz-1:0]        cfg_idx;
   logic [weight_sz-1:0]    cfg_weight;
   logic [width-1:0]        p_data;
   logic [inputs-1:0]       p_grant;
   logic                    p_srdy;
   logic                    p_drdy;

   modport master (
      output c_data, c_srdy, cfg_wr, cfg_idx, cfg_weight, p_drdy,
      input  c_drdy, p_data, p_grant, p_srdy
   );

   modport slave (
      input  c_data, c_srdy, cfg_wr, cfg_idx, cfg_weight, p_drdy,
      output c_drdy, p_data, p_grant, p_srdy
   );
endinterface

// File: rtl/sd_wrrarb_n.sv
// sd_wrrarb_n
// Weighted round-robin arbiter with a one-entry registered output stage.
// Each requester owns a weight and a credit counter; a requester keeps the
// round pointer while it still has credits, so it is served in bursts of
// up to its weight. When nobody with credits is asking, credits are reloaded
// from the weights in a one-cycle bubble.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : sd_wrrarb_n_if slave modport (request, config and output sides)
module sd_wrrarb_n #(
   parameter int inputs    = 4,
   parameter int width     = 8,
   parameter int weight_sz = 3
) (
   input  logic         clk,
   input  logic         reset,
   sd_wrrarb_n_if.slave bus
);
   localparam int idxSz = $clog2(inputs);

   typedef logic [idxSz-1:0]     idx_t;
   typedef logic [idxSz:0]       wide_t;
   typedef logic [weight_sz-1:0] wt_t;

   wt_t [inputs-1:0]  wt_q, wt_d;
   wt_t [inputs-1:0]  cr_q, cr_d;
   idx_t              ptr_q, ptr_d;
   logic [width-1:0]  p_data_q, p_data_d;
   logic [inputs-1:0] p_grant_q, p_grant_d;
   logic              p_srdy_q, p_srdy_d;

   logic [inputs-1:0] eligible;
   logic [inputs-1:0] selOneHot;
   logic [inputs-1:0] cDrdy;
   logic              anyEligible;
   logic              canReload;
   logic              outFree;
   logic              xfer;
   logic              reload;
   logic              found;
   idx_t              sel;
   idx_t              cand;
   idx_t              selNext;
   wide_t             candWide;
   wide_t             nextWide;

   // Arbitration: work out who may go this cycle. Eligibility needs both a
   // request and a remaining credit. The circular scan starts at the round
   // pointer; the pointer is always below inputs, so one conditional
   // subtract is enough to wrap. A reload is only wanted when nobody is
   // eligible but some requester with a nonzero weight is asking, which
   // keeps zero-weight requesters from spinning the reload forever.
   always_comb begin
      eligible  = '0;
      canReload = 1'b0;
      for (int i = 0; i < inputs; i++) begin
         eligible[i] = bus.c_srdy[i] && (cr_q[i] != '0);
         if (bus.c_srdy[i] && (wt_q[i] != '0)) begin
            canReload = 1'b1;
         end
      end
      anyEligible = |eligible;

      sel      = '0;
      found    = 1'b0;
      cand     = '0;
      candWide = '0;
      for (int k = 0; k < inputs; k++) begin
         candWide = {1'b0, ptr_q} + wide_t'(k);
         if (candWide >= wide_t'(inputs)) begin
            candWide = candWide - wide_t'(inputs);
         end
         cand = candWide[idxSz-1:0];
         if (!found && eligible[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end

      nextWide = {1'b0, sel} + wide_t'(1);
      if (nextWide >= wide_t'(inputs)) begin
         nextWide = '0;
      end
      selNext = nextWide[idxSz-1:0];

      selOneHot      = '0;
      selOneHot[sel] = 1'b1;

      // The output register can take a new item when empty or being drained.
      // Reset forces every accept low, and a stalled output freezes credits.
      outFree = !p_srdy_q || bus.p_drdy;
      xfer    = !reset && anyEligible && outFree;
      reload  = !reset && !anyEligible && canReload && outFree;
      cDrdy   = xfer ? selOneHot : '0;
   end

   // Next state: a transfer spends one credit and loads the output register.
   // The pointer stays on the winner while it has credit left and moves past
   // it once the last credit is spent. Reload copies the current (pre-write)
   // weights; a config write only touches the weight, never the credits.
   always_comb begin
      wt_d      = wt_q;
      cr_d      = cr_q;
      ptr_d     = ptr_q;
      p_data_d  = p_data_q;
      p_grant_d = p_grant_q;
      p_srdy_d  = p_srdy_q;

      if (xfer) begin
         cr_d[sel] = cr_q[sel] - wt_t'(1);
         ptr_d     = (cr_q[sel] == wt_t'(1)) ? selNext : sel;
         p_data_d  = bus.c_data[int'(sel)*width +: width];
         p_grant_d = selOneHot;
         p_srdy_d  = 1'b1;
      end else begin
         if (reload) begin
            cr_d = wt_q;
         end
         if (bus.p_drdy) begin
            p_srdy_d  = 1'b0;
            p_grant_d = '0;
         end
      end

      if (bus.cfg_wr && ({1'b0, bus.cfg_idx} < wide_t'(inputs))) begin
         wt_d[bus.cfg_idx] = bus.cfg_weight;
      end
   end

   // State registers. Reset wins over everything else in the same cycle,
   // drops any held output item and restores every weight to 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < inputs; i++) begin
            wt_q[i] <= wt_t'(1);
            cr_q[i] <= '0;
         end
         ptr_q     <= '0;
         p_data_q  <= '0;
         p_grant_q <= '0;
         p_srdy_q  <= 1'b0;
      end else begin
         wt_q      <= wt_d;
         cr_q      <= cr_d;
         ptr_q     <= ptr_d;
         p_data_q  <= p_data_d;
         p_grant_q <= p_grant_d;
         p_srdy_q  <= p_srdy_d;
      end
   end

   assign bus.c_drdy  = cDrdy;
   assign bus.p_data  = p_data_q;
   assign bus.p_grant = p_grant_q;
   assign bus.p_srdy  = p_srdy_q;
endmodule

// File: tb/tb_sd_wrrarb_n.sv
// tb_sd_wrrarb_n
// Self-checking bench for sd_wrrarb_n. A reference model tracks weights,
// credits, the round pointer and output occupancy with plain integers; every
// predicted transfer is queued and a separate monitor pops and compares it
// when the output is accepted downstream.
module tb_sd_wrrarb_n;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int WS = 3;

   typedef struct {
      int           idx;
      logic [W-1:0] data;
   } item_t;

   logic  clk = 1'b0;
   logic  reset;
   int    checks = 0;
   int    errors = 0;
   item_t sbq[$];
   int    obsLog[$];
   int    expLog[$];
   bit    logOn = 1'b0;

   int mWt[N];
   int mCr[N];
   int mPtr;
   bit mOutValid;

   sd_wrrarb_n_if #(.inputs(N), .width(W), .weight_sz(WS)) bus ();

   sd_wrrarb_n #(.inputs(N), .width(W), .weight_sz(WS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always ends even if the stimulus process stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached, required finish before limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Turns a grant vector into an index: -1 for none, -2 for several bits.
   function automatic int grantIdx(input logic [N-1:0] g);
      int idx;
      idx = -1;
      for (int i = 0; i < N; i++) begin
         if (g[i] === 1'b1) idx = (idx == -1) ? i : -2;
      end
      return idx;
   endfunction

   // Monitor: pops the expected item whenever the output is accepted and
   // checks that an idle output never shows a grant.
   always @(negedge clk) begin : monitor
      item_t e;
      if (reset === 1'b0) begin
         if (logOn) obsLog.push_back((bus.p_srdy === 1'b1) ? grantIdx(bus.p_grant) : -1);
         if (bus.p_srdy !== 1'b1) begin
            checks++;
            if (bus.p_grant !== '0) begin
               errors++;
               $display("[TB] FAIL idle_grant: p_grant=%b required 0000", bus.p_grant);
            end
         end else if (bus.p_drdy === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_output: p_grant=%b p_data=%h required no item", bus.p_grant, bus.p_data);
            end else begin
               e = sbq.pop_front();
               if (bus.p_grant !== (N'(1) << e.idx) || bus.p_data !== e.data) begin
                  errors++;
                  $display("[TB] FAIL output_item: p_grant=%b p_data=%h required grant=%b data=%h",
                           bus.p_grant, bus.p_data, N'(1) << e.idx, e.data);
               end
            end
         end
      end
   end

   // Reference model step, evaluated mid-cycle once inputs are settled.
   task automatic modelStep();
      logic [N-1:0] expDrdy;
      int           pick;
      int           j;
      bit           free;
      bit           canReload;
      item_t        it;
      expDrdy = '0;
      pick    = -1;
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            mWt[i] = 1;
            mCr[i] = 0;
         end
         mPtr      = 0;
         mOutValid = 1'b0;
         sbq.delete();
      end else begin
         free = !mOutValid || bus.p_drdy;
         for (int k = 0; k < N; k++) begin
            j = (mPtr + k) % N;
            if (pick < 0 && bus.c_srdy[j] && mCr[j] > 0) pick = j;
         end
         canReload = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (bus.c_srdy[i] && mWt[i] > 0) canReload = 1'b1;
         end
         if (pick >= 0 && free) begin
            expDrdy = N'(1) << pick;
            it.idx  = pick;
            it.data = bus.c_data[pick*W +: W];
            sbq.push_back(it);
            mPtr = (mCr[pick] == 1) ? (pick + 1) % N : pick;
            mCr[pick]--;
            mOutValid = 1'b1;
         end else begin
            if (pick < 0 && free && canReload) begin
               for (int i = 0; i < N; i++) mCr[i] = mWt[i];
            end
            if (free) mOutValid = 1'b0;
         end
         if (bus.cfg_wr) mWt[bus.cfg_idx] = bus.cfg_weight;
      end
      checks++;
      if (bus.c_drdy !== expDrdy) begin
         errors++;
         $display("[TB] FAIL c_drdy: got %b required %b (c_srdy=%b p_drdy=%b)", bus.c_drdy, expDrdy, bus.c_srdy, bus.p_drdy);
      end
   endtask

   // Drives one cycle of inputs with fresh random data, runs the model
   // and returns just after the next rising edge.
   task automatic applyStimulus(input logic rst, input logic [N-1:0] srdy, input logic drdy,
                                input logic cw, input int ci, input int cwt);
      reset          = rst;
      bus.c_srdy     = srdy;
      bus.p_drdy     = drdy;
      bus.cfg_wr     = cw;
      bus.cfg_idx    = 2'(ci);
      bus.cfg_weight = WS'(cwt);
      for (int i = 0; i < N; i++) bus.c_data[i*W +: W] = W'($urandom);
      @(negedge clk);
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic srdy, input logic [N-1:0] grant, input logic [W-1:0] data);
      checks++;
      if (bus.p_srdy !== srdy || bus.p_grant !== grant || bus.p_data !== data) begin
         errors++;
         $display("[TB] FAIL %s: p_srdy=%b p_grant=%b p_data=%h required %b %b %h",
                  name, bus.p_srdy, bus.p_grant, bus.p_data, srdy, grant, data);
      end
   endtask

   // Compares the logged grant indices (-1 = no output) with expLog.
   task automatic checkLog(input string name);
      int n;
      checks++;
      if (obsLog.size() != expLog.size()) begin
         errors++;
         $display("[TB] FAIL %s_len: got %0d entries required %0d", name, obsLog.size(), expLog.size());
      end
      n = (obsLog.size() < expLog.size()) ? obsLog.size() : expLog.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obsLog[i] != expLog[i]) begin
            errors++;
            $display("[TB] FAIL %s[%0d]: grant index %0d required %0d", name, i, obsLog[i], expLog[i]);
         end
      end
      obsLog.delete();
   endtask

   initial begin
      reset          = 1'b1;
      bus.c_srdy     = '0;
      bus.c_data     = '0;
      bus.p_drdy     = 1'b1;
      bus.cfg_wr     = 1'b0;
      bus.cfg_idx    = '0;
      bus.cfg_weight = '0;

      repeat (2) applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 0, 0);
      checkOutput("reset_state", 1'b0, 4'b0000, 8'h00);

      // Weighted round with wt0=3, then a five-cycle downstream stall.
      $display("[TB] weighted round sequence");
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 0, 3);
      logOn = 1'b1;
      repeat (15) applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 0, 0);
      logOn = 1'b0;
      expLog = '{-1, -1, 0, 0, 0, 1, 2, 3, -1, 0, 0, 0, 1, 2, 3};
      checkLog("wrr_sequence");

      $display("[TB] downstream stall");
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 0, 0);
      logOn = 1'b1;
      repeat (5) applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 0, 0);
      repeat (4) applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 0, 0);
      logOn = 1'b0;
      expLog = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
      checkLog("stall_resume");

      // Weight rewrite mid-round only affects the following round.
      $display("[TB] weight write mid-round");
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 0, 0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 0, 3);
      logOn = 1'b1;
      for (int k = 0; k < 13; k++) applyStimulus(1'b0, 4'b1111, 1'b1, (k == 2), 0, 1);
      logOn = 1'b0;
      expLog = '{-1, -1, 0, 0, 0, 1, 2, 3, -1, 0, 1, 2, 3};
      checkLog("cfg_mid_round");

      // Zero weight never granted and never triggers a reload.
      $display("[TB] zero weight requester");
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 0, 0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2, 0);
      logOn = 1'b1;
      repeat (4) applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 0, 0);
      repeat (3) applyStimulus(1'b0, 4'b0110, 1'b1, 1'b0, 0, 0);
      logOn = 1'b0;
      expLog = '{-1, -1, -1, -1, -1, -1, 1};
      checkLog("zero_weight");

      // Reset while an item is held, with a competing cfg write.
      $display("[TB] reset during stall");
      repeat (2) applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 0, 0);
      checkOutput("held_before_reset", 1'b1, 4'b1000, bus.p_data);
      applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 1, 5);
      checkOutput("reset_discard", 1'b0, 4'b0000, 8'h00);
      logOn = 1'b1;
      repeat (6) applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 0, 0);
      logOn = 1'b0;
      expLog = '{-1, -1, 0, 1, 2, 3};
      checkLog("after_reset");

      // Randomized traffic, config writes and occasional reset.
      $display("[TB] random traffic");
      for (int c = 0; c < 800; c++) begin
         applyStimulus(($urandom_range(0, 199) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 7) == 0), int'($urandom_range(0, N-1)), int'($urandom_range(0, 7)));
      end

      repeat (10) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 0, 0);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d items outstanding required 0", sbq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
